// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds and optional FWFT read.
// Define SYNC_FIFO_FLEX_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo_flex #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter bit FWFT          = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count
`ifdef SYNC_FIFO_FLEX_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    if (!(AEMPTY_THRESH >= 0 && AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH)) begin : g_bad_cfg
        $error("sync_fifo_flex: need 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;

    // Occupancy is the registered pointer difference; the extra MSB tells full from empty.
    assign count        = wr_ptr - rd_ptr;
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_empty = (count <= AEMPTY_C);
    assign almost_full  = (count >= AFULL_C);

    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end

    if (FWFT) begin : g_fwft
        // Head word is shown combinationally; zero while empty so reset clears the output.
        assign data_out   = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
        assign data_valid = ~empty;
    end else begin : g_std
        always_ff @(posedge clk) begin
            if (reset) begin
                data_out   <= '0;
                data_valid <= 1'b0;
            end else begin
                data_valid <= rd_acc;
                if (rd_acc) data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
        end
    end

`ifdef SYNC_FIFO_FLEX_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & full & ~rd_acc) overflow <= 1'b1;
            if (rd_en & empty) underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: standard and FWFT instances share stimulus and are checked against a queue model.
module tb_sync_fifo_flex;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] dout_s, dout_f;
    logic       dv_s, dv_f, empty_s, empty_f, full_s, full_f;
    logic       ae_s, ae_f, af_s, af_f;
    logic [4:0] cnt_s, cnt_f;
`ifdef SYNC_FIFO_FLEX_ERR_FLAGS_EN
    logic       ovf_s, udf_s, ovf_f, udf_f;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1'b0)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout_s), .data_valid(dv_s), .empty(empty_s), .full(full_s),
        .almost_empty(ae_s), .almost_full(af_s), .count(cnt_s)
`ifdef SYNC_FIFO_FLEX_ERR_FLAGS_EN
        , .overflow(ovf_s), .underflow(udf_s)
`endif
    );

    sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1'b1)) dut_f (
        .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout_f), .data_valid(dv_f), .empty(empty_f), .full(full_f),
        .almost_empty(ae_f), .almost_full(af_f), .count(cnt_f)
`ifdef SYNC_FIFO_FLEX_ERR_FLAGS_EN
        , .overflow(ovf_f), .underflow(udf_f)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus the last word handed out in standard mode.
    logic [7:0] q[$];
    logic [7:0] m_dout = '0;
    bit         m_dv = 1'b0;
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;
    bit         started = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_dout = '0;
            m_dv = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
            started = 1'b1;
        end else begin
            bit ra, wa;
            ra = rd_en && (q.size() > 0);
            wa = wr_en && ((q.size() < DEPTH) || ra);
            if (wr_en && q.size() == DEPTH && !ra) m_ovf = 1'b1;
            if (rd_en && q.size() == 0) m_udf = 1'b1;
            m_dv = ra;
            if (ra) m_dout = q.pop_front();
            if (wa) q.push_back(data_in);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            int n;
            n = q.size();
            chk("count", int'(cnt_s), n);
            chk("count_f", int'(cnt_f), n);
            chk("empty", int'(empty_s), int'(n == 0));
            chk("empty_f", int'(empty_f), int'(n == 0));
            chk("full", int'(full_s), int'(n == DEPTH));
            chk("full_f", int'(full_f), int'(n == DEPTH));
            chk("almost_empty", int'(ae_s), int'(n <= 2));
            chk("almost_empty_f", int'(ae_f), int'(n <= 2));
            chk("almost_full", int'(af_s), int'(n >= 14));
            chk("almost_full_f", int'(af_f), int'(n >= 14));
            chk("data_valid", int'(dv_s), int'(m_dv));
            chk("data_out", int'(dout_s), int'(m_dout));
            chk("data_valid_f", int'(dv_f), int'(n != 0));
            if (n != 0) chk("data_out_f", int'(dout_f), int'(q[0]));
`ifdef SYNC_FIFO_FLEX_ERR_FLAGS_EN
            chk("overflow", int'(ovf_s), int'(m_ovf));
            chk("underflow", int'(udf_s), int'(m_udf));
            chk("overflow_f", int'(ovf_f), int'(m_ovf));
            chk("underflow_f", int'(udf_f), int'(m_udf));
`endif
        end
    end

    task automatic step(input logic r, input logic w, input logic [7:0] d, input logic rd);
        reset = r;
        wr_en = w;
        data_in = d;
        rd_en = rd;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        int pw, pr;
        step(1, 0, 8'h00, 0);
        step(1, 1, 8'h99, 1);
        chk("rst_count", int'(cnt_s), 0);
        chk("rst_empty", int'(empty_s), 1);
        chk("rst_ae", int'(ae_s), 1);
        chk("rst_full", int'(full_s), 0);
        chk("rst_af", int'(af_s), 0);
        chk("rst_dout", int'(dout_s), 0);
        chk("rst_dv", int'(dv_s), 0);

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            step(0, 1, i[7:0], 0);
            chk("fill_count", int'(cnt_s), i + 1);
            if (i == 1) chk("ae_at2", int'(ae_s), 1);
            if (i == 2) chk("ae_at3", int'(ae_s), 0);
            if (i == 12) chk("af_at13", int'(af_s), 0);
            if (i == 13) chk("af_at14", int'(af_s), 1);
        end
        chk("fill_full", int'(full_s), 1);
        chk("fill_head_f", int'(dout_f), 8'h00);

        // Write while full with no read is dropped
        step(0, 1, 8'hAA, 0);
        chk("ovf_count", int'(cnt_s), 16);
`ifdef SYNC_FIFO_FLEX_ERR_FLAGS_EN
        chk("ovf_flag", int'(ovf_s), 1);
`endif

        // Simultaneous read/write at full
        step(0, 1, 8'h55, 1);
        chk("fullrw_count", int'(cnt_s), 16);
        chk("fullrw_full", int'(full_s), 1);
        chk("fullrw_dout", int'(dout_s), 8'h00);
        chk("fullrw_dv", int'(dv_s), 1);

        for (int i = 1; i < 16; i++) begin
            step(0, 0, 8'h00, 1);
            chk("drain_dout", int'(dout_s), i);
        end
        step(0, 0, 8'h00, 1);
        chk("drain_0x55", int'(dout_s), 8'h55);
        chk("drain_empty", int'(empty_s), 1);

        // Simultaneous read/write at empty
        step(0, 1, 8'h3C, 1);
        chk("emptyrw_count", int'(cnt_s), 1);
        chk("emptyrw_dv", int'(dv_s), 0);
        chk("emptyrw_dout", int'(dout_s), 8'h55);
`ifdef SYNC_FIFO_FLEX_ERR_FLAGS_EN
        chk("udf_flag", int'(udf_s), 1);
`endif
        step(0, 0, 8'h00, 1);
        chk("emptyrw_read", int'(dout_s), 8'h3C);

        // FWFT view and mid-operation reset
        step(0, 1, 8'h11, 0);
        chk("fwft_first", int'(dout_f), 8'h11);
        chk("fwft_dv", int'(dv_f), 1);
        step(0, 1, 8'h22, 0);
        step(0, 0, 8'h00, 1);
        chk("fwft_pop", int'(dout_f), 8'h22);
        chk("fwft_cnt1", int'(cnt_f), 1);
        step(1, 0, 8'h00, 0);
        chk("mid_rst_count", int'(cnt_f), 0);
        chk("mid_rst_empty", int'(empty_f), 1);
        chk("mid_rst_dv", int'(dv_f), 0);
        chk("mid_rst_dout", int'(dout_f), 0);
        chk("mid_rst_dout_s", int'(dout_s), 0);

        // Randomised traffic with shifting write/read bias to reach both boundaries
        pw = 50;
        pr = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) begin
                pw = int'($urandom_range(95, 5));
                pr = int'($urandom_range(95, 5));
            end
            step(($urandom_range(299) == 0) ? 1'b1 : 1'b0,
                 (int'($urandom_range(99)) < pw) ? 1'b1 : 1'b0,
                 8'($urandom),
                 (int'($urandom_range(99)) < pr) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Parametrised single-clock FIFO; next generation of the team's basic synchronous FIFO.
- Adds configurable depth and width, an occupancy count, programmable almost-full and almost-empty thresholds, and a first-word-fall-through (FWFT) read mode.
- Adds defined behaviour when read and write happen in the same cycle at the full and empty boundaries.
- Sits between producer and consumer blocks in the same clock domain.

Parameters:
- DATA_WIDTH, 8, data word width in bits.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH.
- AFULL_THRESH, 2**ADDR_WIDTH-2, almost_full asserts when count >= AFULL_THRESH.
- AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (FWFT=1: pop/acknowledge).
- data_out  out  DATA_WIDTH  read data.
- data_valid  out  1  data_out holds a newly read word (standard mode) or a valid head word (FWFT mode).
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- almost_full  out  1  count >= AFULL_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (reset high at posedge clk): wr_ptr=0, rd_ptr=0, count=0, data_out=0, data_valid=0. This gives empty=1, almost_empty=1, full=0, almost_full=0 (AFULL_THRESH>0). Memory contents are not cleared. Reset overrides all requests in the same cycle.
- Pointers: ADDR_WIDTH+1 bits with natural binary wrap; memory is indexed by the low ADDR_WIDTH bits. No explicit wrap compare.
- Write accept: wr_acc = wr_en & (!full | rd_acc). Writing when full is allowed only if a read is accepted in the same cycle.
- Read accept: rd_acc = rd_en & !empty. A read request when empty is ignored, even if a write happens in the same cycle.
- count next value: +1 on write only, -1 on read only, unchanged on both or neither.
- Flags are decoded from the registered count. They reflect the state after each edge with no extra cycle of lag.
- Rejected requests (write when full with no read; read when empty) leave pointers, count and memory unchanged.
- Standard mode (FWFT=0):
  - data_out <= mem[rd_ptr] on rd_acc, so latency is 1 cycle after the accepting edge.
  - data_valid is a 1-cycle pulse following each rd_acc.
  - data_out holds its value otherwise.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] continuously whenever !empty; data_valid = !empty.
  - rd_en consumes the displayed word, and the next word appears the cycle after rd_acc.
  - The first write into an empty FIFO is visible on data_out the cycle after the write edge.
- Simultaneous read and write at count=DEPTH: both accepted, count stays at DEPTH, full stays 1.
- Simultaneous read and write at count=0: write accepted, read rejected, count becomes 1.
- Parameter legality: the parameters must satisfy 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH. Out-of-range values are a configuration error, flagged by an elaboration-time check.

Optional Feature:
- Macro: SYNC_FIFO_FLEX_ERR_FLAGS_EN.
- When defined, two extra outputs are added: overflow and underflow, each 1 bit.
  - overflow sets at the edge where wr_en & full & !rd_acc.
  - underflow sets at the edge where rd_en & empty.
  - Both are sticky until reset and both reset to 0.
- When not defined, these ports do not exist and illegal requests are silently dropped.

Test Plan:
- Fill/drain, DEPTH=16, FWFT=0: write 0x00..0x0F, then read 16.
  - count goes 1..16; full=1 after the 16th write edge.
  - data_out = 0x00..0x0F in order, each 1 cycle after its rd_en; empty=1 after the last read.
- Overflow attempt: with the FIFO full, write 0xAA with no read.
  - count stays 16 and contents are unchanged.
  - With SYNC_FIFO_FLEX_ERR_FLAGS_EN: overflow=1 next cycle and stays high.
- Full-boundary simultaneous: at count=16, assert wr_en=1 (0x55) and rd_en=1 together.
  - Oldest word is read, 0x55 is stored, count=16, full=1.
  - 0x55 emerges after 15 further reads.
- Empty-boundary simultaneous: at count=0, assert wr_en=1 (0x3C) and rd_en=1.
  - count=1, data_valid stays 0, data_out unchanged.
  - The next rd_en returns 0x3C.
- Thresholds, AFULL_THRESH=14, AEMPTY_THRESH=2: write 14 words.
  - almost_empty deasserts at count=3 and almost_full asserts at count=14.
  - Reading back to count=2 reasserts almost_empty.
- FWFT=1 and reset mid-operation: write 0x11 and 0x22.
  - data_out=0x11 and data_valid=1 the cycle after the first write.
  - rd_en pops, then data_out=0x22.
  - Assert reset with count=1: next cycle count=0, empty=1, data_valid=0, data_out=0.
